// File: rtl/sembol_patlatma.sv
// Symbol elimination stack: pushes W-bit symbols, pops a run of ESLESME equal symbols and counts pops.
// 1-cycle latency; giris_hazir drops permanently once the stack fills, until rst.
module sembol_patlatma #(
  parameter int SEMBOL_W = 1,
  parameter int DERINLIK = 10,
  parameter int ESLESME  = 3,
  parameter int SKOR_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               giris_gecerli,
  input  logic [SEMBOL_W-1:0]                giris_sembol,
  output logic                               giris_hazir,
  output logic [DERINLIK*SEMBOL_W-1:0]       tablo,
  output logic [$clog2(DERINLIK+1)-1:0]      isaretci,
  output logic                               bitti_mi,
  output logic                               patlama,
  output logic [SKOR_W-1:0]                  skor
);
  localparam int PW = $clog2(DERINLIK+1);

  logic [SEMBOL_W-1:0] yigin [DERINLIK];
  logic [DERINLIK-1:0] pencere;
  logic [DERINLIK-1:0] yaz;
  logic                eslesme;
  logic                aktarim;
  int                  pi;

  assign giris_hazir = !bitti_mi;
  assign aktarim     = giris_gecerli && giris_hazir;

  for (genvar g = 0; g < DERINLIK; g++) begin : g_tablo
    assign tablo[g*SEMBOL_W +: SEMBOL_W] = yigin[g];
  end

  // pencere marks the ESLESME-1 entries just below the top that the new symbol would complete
  always_comb begin
    pencere = '0;
    yaz     = '0;
    pi      = int'(isaretci);
    eslesme = (pi >= ESLESME - 1);
    for (int i = 0; i < DERINLIK; i++) begin
      pencere[i] = (i >= pi - (ESLESME - 1)) && (i < pi);
      yaz[i]     = (i == pi);
      if (pencere[i] && (yigin[i] != giris_sembol)) begin
        eslesme = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DERINLIK; i++) begin
        yigin[i] <= '0;
      end
      isaretci <= '0;
      bitti_mi <= 1'b0;
      patlama  <= 1'b0;
      skor     <= '0;
    end else begin
      patlama <= 1'b0;
      if (aktarim) begin
        for (int i = 0; i < DERINLIK; i++) begin
          if (eslesme && pencere[i]) begin
            yigin[i] <= '0;
          end else if (!eslesme && yaz[i]) begin
            yigin[i] <= giris_sembol;
          end
        end
        if (eslesme) begin
          isaretci <= isaretci - PW'(ESLESME - 1);
          patlama  <= 1'b1;
          if (skor != {SKOR_W{1'b1}}) begin
            skor <= skor + 1'b1;
          end
        end else begin
          isaretci <= isaretci + 1'b1;
          if (isaretci == PW'(DERINLIK - 1)) begin
            bitti_mi <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sembol_patlatma.sv
// Directed bench: a binary 3-match stack and a 2-bit 4-match stack with a 2-bit score.
module tb_sembol_patlatma;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // configuration A: SEMBOL_W=1, DERINLIK=10, ESLESME=3, SKOR_W=8
  logic       rst_a, vld_a, sym_a, rdy_a, bitti_a, pat_a;
  logic [9:0] tablo_a;
  logic [3:0] ptr_a;
  logic [7:0] skor_a;

  // configuration B: SEMBOL_W=2, DERINLIK=10, ESLESME=4, SKOR_W=2
  logic        rst_b, vld_b, rdy_b, bitti_b, pat_b;
  logic [1:0]  sym_b, skor_b;
  logic [19:0] tablo_b;
  logic [3:0]  ptr_b;

  sembol_patlatma #(.SEMBOL_W(1), .DERINLIK(10), .ESLESME(3), .SKOR_W(8)) u_a (
    .clk(clk), .rst(rst_a), .giris_gecerli(vld_a), .giris_sembol(sym_a),
    .giris_hazir(rdy_a), .tablo(tablo_a), .isaretci(ptr_a), .bitti_mi(bitti_a),
    .patlama(pat_a), .skor(skor_a));

  sembol_patlatma #(.SEMBOL_W(2), .DERINLIK(10), .ESLESME(4), .SKOR_W(2)) u_b (
    .clk(clk), .rst(rst_b), .giris_gecerli(vld_b), .giris_sembol(sym_b),
    .giris_hazir(rdy_b), .tablo(tablo_b), .isaretci(ptr_b), .bitti_mi(bitti_b),
    .patlama(pat_b), .skor(skor_b));

  int hata = 0;
  int toplam = 0;

  task automatic kontrol(input string tag, input logic [63:0] gozlenen, input logic [63:0] beklenen);
    toplam++;
    if (gozlenen !== beklenen) begin
      hata++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, gozlenen, beklenen);
    end
  endtask

  // one clock with the given inputs; returns #1 after the edge so outputs can be sampled
  task automatic adim_a(input logic r, input logic v, input logic s);
    rst_a = r; vld_a = v; sym_a = s;
    @(posedge clk); #1;
    rst_a = 1'b0; vld_a = 1'b0;
  endtask

  task automatic adim_b(input logic r, input logic v, input logic [1:0] s);
    rst_b = r; vld_b = v; sym_b = s;
    @(posedge clk); #1;
    rst_b = 1'b0; vld_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; vld_a = 1'b0; sym_a = 1'b0;
    rst_b = 1'b0; vld_b = 1'b0; sym_b = 2'd0;
    @(posedge clk); #1;

    // reset state
    adim_a(1'b1, 1'b0, 1'b0);
    kontrol("rst_ptr", 64'(ptr_a), 64'd0);
    kontrol("rst_tablo", 64'(tablo_a), 64'd0);
    kontrol("rst_bitti", 64'(bitti_a), 64'd0);
    kontrol("rst_patlama", 64'(pat_a), 64'd0);
    kontrol("rst_skor", 64'(skor_a), 64'd0);
    kontrol("rst_hazir", 64'(rdy_a), 64'd1);

    // 1,1,1 back to back pops the run
    adim_a(1'b0, 1'b1, 1'b1);
    adim_a(1'b0, 1'b1, 1'b1);
    kontrol("t1_ptr2", 64'(ptr_a), 64'd2);
    kontrol("t1_tablo2", 64'(tablo_a), 64'h3);
    kontrol("t1_nopat", 64'(pat_a), 64'd0);
    adim_a(1'b0, 1'b1, 1'b1);
    kontrol("t1_ptr", 64'(ptr_a), 64'd0);
    kontrol("t1_tablo", 64'(tablo_a), 64'd0);
    kontrol("t1_pat", 64'(pat_a), 64'd1);
    kontrol("t1_skor", 64'(skor_a), 64'd1);
    adim_a(1'b0, 1'b0, 1'b0);
    kontrol("t1_pat_end", 64'(pat_a), 64'd0);

    // 1,1,0,0,0 pops the zeros only, then 1 pops the ones
    adim_a(1'b1, 1'b0, 1'b0);
    adim_a(1'b0, 1'b1, 1'b1);
    adim_a(1'b0, 1'b1, 1'b1);
    adim_a(1'b0, 1'b1, 1'b0);
    adim_a(1'b0, 1'b1, 1'b0);
    kontrol("t3_ptr4", 64'(ptr_a), 64'd4);
    adim_a(1'b0, 1'b1, 1'b0);
    kontrol("t3_ptr", 64'(ptr_a), 64'd2);
    kontrol("t3_tablo", 64'(tablo_a), 64'h3);
    kontrol("t3_skor", 64'(skor_a), 64'd1);
    kontrol("t3_pat", 64'(pat_a), 64'd1);
    adim_a(1'b0, 1'b1, 1'b1);
    kontrol("t3_ptr0", 64'(ptr_a), 64'd0);
    kontrol("t3_skor2", 64'(skor_a), 64'd2);
    kontrol("t3_pat2", 64'(pat_a), 64'd1);

    // idle gaps do not break a run
    adim_a(1'b1, 1'b0, 1'b0);
    adim_a(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      adim_a(1'b0, 1'b0, 1'b0);
      kontrol("t4_idle_ptr", 64'(ptr_a), 64'd1);
    end
    adim_a(1'b0, 1'b1, 1'b1);
    kontrol("t4_ptr", 64'(ptr_a), 64'd2);
    kontrol("t4_nopat", 64'(pat_a), 64'd0);
    adim_a(1'b0, 1'b1, 1'b1);
    kontrol("t4_pop_ptr", 64'(ptr_a), 64'd0);
    kontrol("t4_pop_pat", 64'(pat_a), 64'd1);

    // alternating symbols fill the stack
    adim_a(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      adim_a(1'b0, 1'b1, 1'(i % 2));
      if (i == 8) begin
        kontrol("t2_bitti9", 64'(bitti_a), 64'd0);
        kontrol("t2_hazir9", 64'(rdy_a), 64'd1);
      end
    end
    kontrol("t2_ptr", 64'(ptr_a), 64'd10);
    kontrol("t2_tablo", 64'(tablo_a), 64'h2AA);
    kontrol("t2_bitti", 64'(bitti_a), 64'd1);
    kontrol("t2_hazir", 64'(rdy_a), 64'd0);
    adim_a(1'b0, 1'b1, 1'b0);
    kontrol("t2_full_ptr", 64'(ptr_a), 64'd10);
    kontrol("t2_full_tablo", 64'(tablo_a), 64'h2AA);
    kontrol("t2_full_pat", 64'(pat_a), 64'd0);
    kontrol("t2_full_bitti", 64'(bitti_a), 64'd1);

    // reset wins over a simultaneous transfer
    adim_a(1'b1, 1'b1, 1'b1);
    kontrol("t5_ptr", 64'(ptr_a), 64'd0);
    kontrol("t5_tablo", 64'(tablo_a), 64'd0);
    kontrol("t5_bitti", 64'(bitti_a), 64'd0);
    kontrol("t5_skor", 64'(skor_a), 64'd0);
    kontrol("t5_hazir", 64'(rdy_a), 64'd1);
    adim_a(1'b0, 1'b0, 1'b0);
    kontrol("t5_dropped", 64'(ptr_a), 64'd0);

    // 2-bit symbols, run of 4, 2-bit saturating score
    adim_b(1'b1, 1'b0, 2'd0);
    kontrol("t6_rst_skor", 64'(skor_b), 64'd0);
    for (int i = 0; i < 3; i++) adim_b(1'b0, 1'b1, 2'd2);
    kontrol("t6_ptr3", 64'(ptr_b), 64'd3);
    for (int i = 0; i < 3; i++) adim_b(1'b0, 1'b1, 2'd3);
    kontrol("t6_ptr6", 64'(ptr_b), 64'd6);
    kontrol("t6_nopat", 64'(pat_b), 64'd0);
    adim_b(1'b0, 1'b1, 2'd3);
    kontrol("t6_pop_ptr", 64'(ptr_b), 64'd3);
    kontrol("t6_pop_tablo", 64'(tablo_b), 64'h2A);
    kontrol("t6_pop_skor", 64'(skor_b), 64'd1);
    kontrol("t6_pop_pat", 64'(pat_b), 64'd1);
    adim_b(1'b0, 1'b1, 2'd2);
    kontrol("t6_pop2_ptr", 64'(ptr_b), 64'd0);
    kontrol("t6_pop2_tablo", 64'(tablo_b), 64'd0);
    kontrol("t6_pop2_skor", 64'(skor_b), 64'd2);
    for (int i = 0; i < 3; i++) adim_b(1'b0, 1'b1, 2'd1);
    kontrol("t6_tablo111", 64'(tablo_b), 64'h15);
    adim_b(1'b0, 1'b1, 2'd1);
    kontrol("t6_skor3", 64'(skor_b), 64'd3);
    for (int i = 0; i < 4; i++) adim_b(1'b0, 1'b1, 2'd1);
    kontrol("t6_sat_ptr", 64'(ptr_b), 64'd0);
    kontrol("t6_sat_pat", 64'(pat_b), 64'd1);
    kontrol("t6_sat_skor", 64'(skor_b), 64'd3);

    $display("Result: errors=%0d of %0d checks", hata, toplam);
    $finish;
  end
endmodule
